// File: rtl/instruction_fetch_responder.sv
// Instruction fetch responder: serves fetches from local SRAM or the bus.
// Misaligned fetches fault immediately; bus fetches time out with an error.
module instruction_fetch_responder #(
    parameter int          SRAM_ADDR_WIDTH = 9,
    parameter logic [7:0]  LOCAL_REGION    = 8'h00,
    parameter int          TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetchEnable,
    input  logic [31:0]                fetchAddress,
    output logic [31:0]                fetchData,
    output logic                       fetchValid,
    output logic                       fetchError,
    output logic                       fetchBusy,
    output logic                       sramEnable,
    output logic [SRAM_ADDR_WIDTH-1:0] sramAddress,
    input  logic [31:0]                sramDataRead,
    output logic                       wbCyc,
    output logic                       wbStb,
    output logic [31:0]                wbAdr,
    input  logic [31:0]                wbDatRead,
    input  logic                       wbAck,
    input  logic                       wbErr
);

    typedef enum logic [1:0] {
        IDLE,
        SRAM_WAIT,
        BUS_WAIT
    } state_t;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [7:0]  TO_LIM = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic [31:0] adr_q, adr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        sram_en;
    logic        misaligned;
    logic        is_local;
    logic        unused_addr;

    assign misaligned  = fetchAddress[1:0] != 2'b00;
    assign is_local    = fetchAddress[31:24] == LOCAL_REGION;
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign unused_addr = ^fetchAddress;

    // Next-state and response selection for the fetch FSM
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        sram_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetchEnable) begin
                    if (misaligned) begin
                        data_d  = NOP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (is_local) begin
                        sram_en = 1'b1;
                        state_d = SRAM_WAIT;
                    end else begin
                        adr_d   = fetchAddress;
                        cnt_d   = 8'd0;
                        state_d = BUS_WAIT;
                    end
                end
            end
            SRAM_WAIT: begin
                data_d  = sramDataRead;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            BUS_WAIT: begin
                cnt_d = cnt_inc;
                if (wbErr || (!wbAck && cnt_inc >= TO_LIM)) begin
                    data_d  = NOP;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (wbAck) begin
                    data_d  = wbDatRead;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset aborts any outstanding fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= NOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            adr_q   <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fetchData   = data_q;
    assign fetchValid  = valid_q;
    assign fetchError  = err_q;
    assign fetchBusy   = state_q != IDLE;
    assign sramEnable  = sram_en && !rst;
    assign sramAddress = fetchAddress[SRAM_ADDR_WIDTH+1:2];
    assign wbCyc       = state_q == BUS_WAIT;
    assign wbStb       = state_q == BUS_WAIT;
    assign wbAdr       = adr_q;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Randomized bench for instruction_fetch_responder.
// Expected latency/data come from a transaction-level model.
module tb_instruction_fetch_responder;

    localparam int          AW  = 9;
    localparam int          TO  = 16;
    localparam logic [7:0]  LR  = 8'h00;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          fetchEnable;
    logic [31:0]   fetchAddress;
    logic [31:0]   fetchData;
    logic          fetchValid;
    logic          fetchError;
    logic          fetchBusy;
    logic          sramEnable;
    logic [AW-1:0] sramAddress;
    logic [31:0]   sramDataRead;
    logic          wbCyc;
    logic          wbStb;
    logic [31:0]   wbAdr;
    logic [31:0]   wbDatRead;
    logic          wbAck;
    logic          wbErr;

    int            vectors;
    int            miscompares;
    logic [31:0]   last_data;

    instruction_fetch_responder #(
        .SRAM_ADDR_WIDTH(AW),
        .LOCAL_REGION   (LR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetchEnable (fetchEnable),
        .fetchAddress(fetchAddress),
        .fetchData   (fetchData),
        .fetchValid  (fetchValid),
        .fetchError  (fetchError),
        .fetchBusy   (fetchBusy),
        .sramEnable  (sramEnable),
        .sramAddress (sramAddress),
        .sramDataRead(sramDataRead),
        .wbCyc       (wbCyc),
        .wbStb       (wbStb),
        .wbAdr       (wbAdr),
        .wbDatRead   (wbDatRead),
        .wbAck       (wbAck),
        .wbErr       (wbErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One fetch transaction. mode: 0 ack, 1 err, 2 ack+err, 3 silent.
    // k is the 1-based bus-wait cycle carrying the bus reply.
    task automatic fetch(input logic [31:0] addr, input int mode,
                         input int k, input logic [31:0] d,
                         input bit hold_en);
        bit          mis;
        bit          loc;
        bit          bus;
        int          lat;
        logic [31:0] exp_d;
        bit          exp_e;
        mis = addr[1:0] != 2'b00;
        loc = !mis && addr[31:24] == LR;
        bus = !mis && !loc;
        if (mis) begin
            lat = 1; exp_d = NOP; exp_e = 1'b1;
        end else if (loc) begin
            lat = 2; exp_d = d; exp_e = 1'b0;
        end else if (mode == 3) begin
            lat = TO + 1; exp_d = NOP; exp_e = 1'b1;
        end else begin
            lat = k + 1;
            exp_d = (mode == 0) ? d : NOP;
            exp_e = (mode != 0);
        end
        fetchEnable  = 1'b1;
        fetchAddress = addr;
        sramDataRead = $urandom;
        wbDatRead    = $urandom;
        wbAck        = 1'b0;
        wbErr        = 1'b0;
        @(negedge clk);
        chk("accept_busy", fetchBusy, 0);
        chk("accept_valid", fetchValid, 0);
        chk("data_hold", fetchData, last_data);
        chk("sram_en", sramEnable, loc);
        if (loc) chk("sram_adr", sramAddress, addr[AW+1:2]);
        chk("accept_cyc", wbCyc, 0);
        for (int c = 1; c <= lat; c++) begin
            tick;
            fetchEnable  = hold_en && (c < lat);
            fetchAddress = $urandom;
            sramDataRead = (loc && c == 1) ? d : $urandom;
            wbDatRead    = (bus && c == k) ? d : $urandom;
            if (bus) begin
                wbAck = (mode == 0 || mode == 2) && c == k;
                wbErr = (mode == 1 || mode == 2) && c == k;
            end else begin
                wbAck = 1'($urandom_range(0, 1));
                wbErr = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (c < lat) begin
                chk("wait_valid", fetchValid, 0);
                chk("wait_busy", fetchBusy, 1);
                chk("wait_cyc", wbCyc, bus);
                chk("wait_stb", wbStb, bus);
                chk("wait_sram_en", sramEnable, 0);
                if (bus) chk("wb_adr", wbAdr, addr);
            end else begin
                chk("resp_valid", fetchValid, 1);
                chk("resp_error", fetchError, exp_e);
                chk("resp_data", fetchData, exp_d);
                chk("resp_cyc", wbCyc, 0);
                chk("resp_busy", fetchBusy, 0);
            end
        end
        last_data = exp_d;
        tick;
        fetchEnable = 1'b0;
        wbAck       = 1'b0;
        wbErr       = 1'b0;
    endtask

    task automatic reset_in_bus_wait;
        fetchEnable  = 1'b1;
        fetchAddress = 32'h3000_0000;
        tick;
        fetchEnable = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_cyc_still", wbCyc, 1);
        tick;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            wbAck = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("rst_cyc", wbCyc, 0);
            chk("rst_busy", fetchBusy, 0);
            chk("rst_valid", fetchValid, 0);
            chk("rst_data", fetchData, NOP);
            tick;
        end
        wbAck     = 1'b0;
        last_data = NOP;
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        vectors      = 0;
        miscompares  = 0;
        last_data    = NOP;
        rst          = 1'b1;
        fetchEnable  = 1'b1;
        fetchAddress = 32'h0000_0010;
        sramDataRead = 32'd0;
        wbDatRead    = 32'd0;
        wbAck        = 1'b0;
        wbErr        = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("rst_data0", fetchData, NOP);
        chk("rst_valid0", fetchValid, 0);
        chk("rst_error0", fetchError, 0);
        chk("rst_busy0", fetchBusy, 0);
        chk("rst_cyc0", wbCyc, 0);
        chk("rst_stb0", wbStb, 0);
        chk("rst_adr0", wbAdr, 0);
        chk("rst_sram0", sramEnable, 0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        fetchEnable = 1'b0;
        tick;

        fetch(32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_0006, 0, 1, 32'h0, 1'b0);
        fetch(32'h3000_0000, 0, 3, 32'h1234_5678, 1'b0);
        fetch(32'h3000_0000, 3, 1, 32'h0, 1'b0);
        fetch(32'h3000_0000, 2, 2, 32'hCAFE_F00D, 1'b1);
        fetch(32'h3000_0000, 0, TO, 32'hA5A5_5A5A, 1'b1);
        fetch(32'h3000_0004, 1, TO, 32'h0BAD_0BAD, 1'b0);
        reset_in_bus_wait();
        fetch(32'h0000_0010, 0, 1, 32'hDEAD_BEEF, 1'b0);

        for (int n = 0; n < 150; n++) begin
            a    = $urandom;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                if (a[1:0] == 2'b00) a[0] = 1'b1;
            end else if (kind == 1) begin
                a[31:24] = LR;
                a[1:0]   = 2'b00;
            end else begin
                a[1:0] = 2'b00;
                if (a[31:24] == LR) a[31:24] = 8'h30;
            end
            fetch(a, $urandom_range(0, 3), $urandom_range(1, TO),
                  $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
